// File: rtl/mem_stage.sv
// Memory stage that splits each 32-bit load/store into two 16-bit SRAM half-accesses.
// Optional macro SRAM_RANGE_CHECK_EN adds an out-of-range guard with a sticky addr_err flag.
module mem_stage #(
    parameter int SRAM_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_result,
    input  logic [31:0] Val_Rm,
    output logic [31:0] mem_read_value,
    output logic        ready,
    output logic        freeze,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_DQ_oe,
    output logic        SRAM_WE_N,
    output logic        addr_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LO   = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam logic [3:0] LAST = 4'(SRAM_WAIT - 1);

    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic [3:0]  cnt_reg;
    logic [3:0]  cnt_next;
    logic        op_write_reg;
    logic        request;
    logic        phase_last;
    logic        in_access;
    logic        strobe;
    logic        out_of_range;
    logic [31:0] w;
    logic        unused_bits;

    assign request    = MEM_R_EN | MEM_W_EN;
    assign w          = ALU_result - 32'd1024;
    assign phase_last = (cnt_reg == LAST);

`ifdef SRAM_RANGE_CHECK_EN
    // Negative offsets also land here because w is treated as unsigned.
    assign out_of_range = |w[31:19];
    assign unused_bits  = ^w[1:0];
`else
    assign out_of_range = 1'b0;
    assign unused_bits  = ^{w[31:19], w[1:0]};
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (request) begin
                    cnt_next   = 4'd0;
                    state_next = out_of_range ? DONE : LO;
                end
            end
            LO: begin
                if (phase_last) begin
                    cnt_next   = 4'd0;
                    state_next = HI;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            HI: begin
                if (phase_last) begin
                    cnt_next   = 4'd0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            op_write_reg   <= 1'b0;
            mem_read_value <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == IDLE && request) begin
                op_write_reg <= MEM_W_EN;
                // A rejected load must not leave stale data behind.
                if (out_of_range && !MEM_W_EN)
                    mem_read_value <= 32'd0;
            end
            if (!op_write_reg && phase_last) begin
                if (state_reg == LO)
                    mem_read_value[15:0] <= SRAM_DQ_in;
                if (state_reg == HI)
                    mem_read_value[31:16] <= SRAM_DQ_in;
            end
        end
    end

`ifdef SRAM_RANGE_CHECK_EN
    logic addr_err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            addr_err_reg <= 1'b0;
        else if (state_reg == IDLE && request && out_of_range)
            addr_err_reg <= 1'b1;
    end

    assign addr_err = addr_err_reg;
`else
    assign addr_err = 1'b0;
`endif

    // Strobes derive purely from registered state so reset drops them at once.
    assign in_access   = (state_reg == LO) || (state_reg == HI);
    assign strobe      = in_access && op_write_reg;
    assign ready       = ((state_reg == IDLE) && !request) || (state_reg == DONE);
    assign freeze      = ~ready;
    assign SRAM_ADDR   = in_access ? {w[18:2], (state_reg == HI)} : 18'd0;
    assign SRAM_WE_N   = ~strobe;
    assign SRAM_DQ_oe  = strobe;
    assign SRAM_DQ_out = !strobe ? 16'd0 :
                         (state_reg == HI) ? Val_Rm[31:16] : Val_Rm[15:0];

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: SRAM_WAIT=3 instance with a small SRAM model,
// plus a SRAM_WAIT=1 instance for back-to-back single-cycle-phase reads.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] ALU_result, Val_Rm;
    logic [31:0] mem_read_value;
    logic        ready, freeze;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
    logic        SRAM_DQ_oe, SRAM_WE_N, addr_err;

    logic        MEM_R_EN1;
    logic [31:0] ALU_result1;
    logic [31:0] mem_read_value1;
    logic        ready1, freeze1;
    logic [17:0] SRAM_ADDR1;
    logic [15:0] SRAM_DQ_out1, SRAM_DQ_in1;
    logic        SRAM_DQ_oe1, SRAM_WE_N1, addr_err1;

    logic [15:0] sram  [0:63];
    logic [15:0] sram1 [0:63];
    logic        load_en;
    logic [5:0]  load_addr;
    logic [15:0] load_data;

    logic [17:0] addr_log [0:15];
    logic        we_log   [0:15];
    logic [15:0] dq_log   [0:15];

    int checks = 0;
    int errors = 0;
    int lows;
    int we_lows;
    logic [7:0] pattern;

    mem_stage #(.SRAM_WAIT(3)) dut (
        .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .ALU_result(ALU_result), .Val_Rm(Val_Rm), .mem_read_value(mem_read_value),
        .ready(ready), .freeze(freeze), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_in(SRAM_DQ_in), .SRAM_DQ_oe(SRAM_DQ_oe),
        .SRAM_WE_N(SRAM_WE_N), .addr_err(addr_err)
    );

    mem_stage #(.SRAM_WAIT(1)) dut1 (
        .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN1), .MEM_W_EN(1'b0),
        .ALU_result(ALU_result1), .Val_Rm(32'd0), .mem_read_value(mem_read_value1),
        .ready(ready1), .freeze(freeze1), .SRAM_ADDR(SRAM_ADDR1),
        .SRAM_DQ_out(SRAM_DQ_out1), .SRAM_DQ_in(SRAM_DQ_in1), .SRAM_DQ_oe(SRAM_DQ_oe1),
        .SRAM_WE_N(SRAM_WE_N1), .addr_err(addr_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_en)
            sram[load_addr] <= load_data;
        else if (SRAM_WE_N === 1'b0)
            sram[SRAM_ADDR[5:0]] <= SRAM_DQ_out;
    end

    assign SRAM_DQ_in  = sram[SRAM_ADDR[5:0]];
    assign SRAM_DQ_in1 = sram1[SRAM_ADDR1[5:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Logs each ready-low cycle from the current sample point until ready rises.
    task automatic run_access(output int n_low);
        n_low = 0;
        while (ready !== 1'b1 && n_low < 40) begin
            if (n_low < 16) begin
                addr_log[n_low] = SRAM_ADDR;
                we_log[n_low]   = SRAM_WE_N;
                dq_log[n_low]   = SRAM_DQ_out;
            end
            n_low++;
            @(negedge clk); #1;
        end
        $display("access done: low_cycles=%0d mem_read_value=%h", n_low, mem_read_value);
    endtask

    task automatic count_we(output int n);
        n = 0;
        for (int i = 0; i < 16; i++)
            if (we_log[i] === 1'b0) n++;
    endtask

    task automatic end_access;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        @(negedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        MEM_R_EN = 0; MEM_W_EN = 0; ALU_result = 0; Val_Rm = 0;
        MEM_R_EN1 = 0; ALU_result1 = 0;
        load_en = 0; load_addr = 0; load_data = 0;
        for (int i = 0; i < 16; i++) begin
            addr_log[i] = '0; we_log[i] = 1'b1; dq_log[i] = '0;
        end
        sram1[0] = 16'h1111; sram1[1] = 16'h2222; sram1[2] = 16'h3333; sram1[3] = 16'h4444;

        // Preload read data while the DUT is held in reset.
        @(negedge clk); #1;
        load_en = 1; load_addr = 6'd4; load_data = 16'hBEEF;
        @(negedge clk); #1;
        load_addr = 6'd5; load_data = 16'hDEAD;
        @(negedge clk); #1;
        load_en = 0;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_freeze", {31'd0, freeze}, 32'd0);
        check("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("rst_oe", {31'd0, SRAM_DQ_oe}, 32'd0);
        check("rst_mrv", mem_read_value, 32'd0);
        check("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk); #1;

        // Load from 1032: halfwords 4 then 5.
        MEM_R_EN = 1; ALU_result = 32'd1032; #1;
        check("rd_freeze_start", {31'd0, freeze}, 32'd1);
        run_access(lows);
        check("rd_low_cycles", lows, 32'd7);
        check("rd_mrv", mem_read_value, 32'hDEADBEEF);
        check("rd_freeze_done", {31'd0, freeze}, 32'd0);
        check("rd_addr_lo", {14'd0, addr_log[3]}, 32'd4);
        check("rd_addr_hi", {14'd0, addr_log[4]}, 32'd5);
        check("rd_addr_idle", {14'd0, addr_log[0]}, 32'd0);
        count_we(we_lows);
        check("rd_no_we", we_lows, 32'd0);
        end_access();
        check("idle_ready", {31'd0, ready}, 32'd1);

        // Store 0x12345678 at 1024.
        MEM_W_EN = 1; ALU_result = 32'd1024; Val_Rm = 32'h12345678; #1;
        run_access(lows);
        check("wr_low_cycles", lows, 32'd7);
        count_we(we_lows);
        check("wr_we_cycles", we_lows, 32'd6);
        for (int i = 1; i <= 6; i++) begin
            check("wr_addr", {14'd0, addr_log[i]}, (i <= 3) ? 32'd0 : 32'd1);
            check("wr_dq", {16'd0, dq_log[i]}, (i <= 3) ? 32'h5678 : 32'h1234);
        end
        check("wr_mrv_kept", mem_read_value, 32'hDEADBEEF);
        check("wr_done_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        end_access();
        check("wr_sram0", {16'd0, sram[0]}, 32'h5678);
        check("wr_sram1", {16'd0, sram[1]}, 32'h1234);

        // Both enables high: must behave as a store to halfwords 2,3.
        MEM_R_EN = 1; MEM_W_EN = 1; ALU_result = 32'd1028; Val_Rm = 32'hCAFEF00D; #1;
        run_access(lows);
        check("both_low_cycles", lows, 32'd7);
        count_we(we_lows);
        check("both_we_cycles", we_lows, 32'd6);
        check("both_addr_lo", {14'd0, addr_log[1]}, 32'd2);
        check("both_addr_hi", {14'd0, addr_log[6]}, 32'd3);
        check("both_dq_lo", {16'd0, dq_log[2]}, 32'hF00D);
        check("both_dq_hi", {16'd0, dq_log[5]}, 32'hCAFE);
        check("both_mrv_kept", mem_read_value, 32'hDEADBEEF);
        end_access();
        check("both_sram2", {16'd0, sram[2]}, 32'hF00D);
        check("both_sram3", {16'd0, sram[3]}, 32'hCAFE);

        // Reset during the second HI cycle of a load, request kept high.
        MEM_R_EN = 1; ALU_result = 32'd1032; Val_Rm = 0; #1;
        repeat (5) begin @(negedge clk); #1; end
        check("mid_addr_hi", {14'd0, SRAM_ADDR}, 32'd5);
        check("mid_mrv_lo", {16'd0, mem_read_value[15:0]}, 32'hBEEF);
        rst = 1'b1; #1;
        check("mid_rst_ready", {31'd0, ready}, 32'd0);
        check("mid_rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("mid_rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
        check("mid_rst_mrv", mem_read_value, 32'd0);
        rst = 1'b0; #1;
        run_access(lows);
        check("restart_low_cycles", lows, 32'd7);
        check("restart_addr_lo", {14'd0, addr_log[1]}, 32'd4);
        check("restart_mrv", mem_read_value, 32'hDEADBEEF);
        end_access();

        // Load at 0: offset is negative.
        MEM_R_EN = 1; ALU_result = 32'd0; #1;
        run_access(lows);
`ifdef SRAM_RANGE_CHECK_EN
        check("range_low_cycles", lows, 32'd1);
        check("range_no_addr", {14'd0, addr_log[0]}, 32'd0);
        check("range_mrv", mem_read_value, 32'd0);
        check("range_addr_err", {31'd0, addr_err}, 32'd1);
        end_access();
        check("range_err_sticky", {31'd0, addr_err}, 32'd1);
`else
        check("wrap_low_cycles", lows, 32'd7);
        check("wrap_addr_lo", {14'd0, addr_log[1]}, 32'h3FE00);
        check("wrap_addr_hi", {14'd0, addr_log[4]}, 32'h3FE01);
        check("wrap_mrv", mem_read_value, 32'h12345678);
        check("wrap_addr_err", {31'd0, addr_err}, 32'd0);
        end_access();
`endif

        // SRAM_WAIT=1: back-to-back loads at 1024 then 1028.
        MEM_R_EN1 = 1; ALU_result1 = 32'd1024; #1;
        pattern = 8'd0;
        for (int i = 0; i < 8; i++) begin
            pattern[i] = ready1;
            if (i == 3) begin
                check("w1_mrv_a", mem_read_value1, 32'h22221111);
                ALU_result1 = 32'd1028;
            end
            if (i == 7) begin
                check("w1_mrv_b", mem_read_value1, 32'h44443333);
                MEM_R_EN1 = 0;
            end
            if (i == 1)
                check("w1_addr_lo", {14'd0, SRAM_ADDR1}, 32'd0);
            if (i == 6)
                check("w1_addr_hi", {14'd0, SRAM_ADDR1}, 32'd3);
            $display("w1 cycle %0d ready=%0b addr=%h", i, ready1, SRAM_ADDR1);
            @(negedge clk); #1;
        end
        check("w1_ready_pattern", {24'd0, pattern}, 32'h88);
        check("w1_idle_ready", {31'd0, ready1}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
